pht_update_ctrl: RTL

- Owns the single write port of the gshare pattern history table (2-bit counters, 2^IDX_W entries) and the committed global history register (GHR).
- Accepts resolved branch/jump outcomes from the execute stage into a small FIFO and retires one read-modify-write counter update per cycle.
- Clears the table by sweep after reset and on request.
- Exports GHR to fetch for index hashing.

---
 rtl/pht_update_ctrl_if.sv | 23 ++
 rtl/pht_update_ctrl.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/pht_update_ctrl_if.sv
// Resolved control-transfer channel from execute into the PHT update controller.
interface pht_update_ctrl_if #(
    parameter int unsigned IDX_W = 10
);
    logic             upd_valid;
    logic             upd_ready;
    logic             upd_is_br;
    logic             upd_is_jmp;
    logic             upd_taken;
    logic             upd_pred_taken;
    logic [IDX_W-1:0] upd_pc;
    logic [IDX_W-1:0] upd_ghr;

    modport master (
        output upd_valid, upd_is_br, upd_is_jmp, upd_taken, upd_pred_taken, upd_pc, upd_ghr,
        input  upd_ready
    );

    modport slave (
        input  upd_valid, upd_is_br, upd_is_jmp, upd_taken, upd_pred_taken, upd_pc, upd_ghr,
        output upd_ready
    );
endinterface

// File: rtl/pht_update_ctrl.sv
// Gshare PHT write-port owner: queues resolved branches/jumps, retires one RMW counter update
// per cycle, keeps the committed GHR and sweeps the table clear. PHT_STATS_EN adds retire stats.
module pht_update_ctrl #(
    parameter int unsigned IDX_W    = 10,
    parameter int unsigned DEPTH    = 4,
    parameter logic [1:0]  INIT_CNT = 2'b01
) (
    input  logic             clk,
    input  logic             rst_n,
    pht_update_ctrl_if.slave upd,
    input  logic             clr_req,
    output logic [IDX_W-1:0] pht_raddr,
    input  logic [1:0]       pht_rdata,
    output logic             pht_we,
    output logic [IDX_W-1:0] pht_waddr,
    output logic [1:0]       pht_wdata,
    output logic [IDX_W-1:0] ghr,
    output logic             busy
`ifdef PHT_STATS_EN
    ,
    output logic [31:0]      stat_upd,
    output logic [31:0]      stat_mis
`endif
);

    localparam int unsigned      PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned      CNT_W    = $clog2(DEPTH + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = '1;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    typedef struct packed {
`ifdef PHT_STATS_EN
        logic             pred_taken;
`endif
        logic             is_jmp;
        logic             taken;
        logic [IDX_W-1:0] pc;
        logic [IDX_W-1:0] ghr;
    } entry_t;

    state_t           state_q;
    logic [IDX_W-1:0] sweep_q;
    logic [IDX_W-1:0] ghr_q;
    logic [IDX_W-1:0] raddr_last_q;
    logic [IDX_W-1:0] waddr_last_q;
    entry_t           fifo_mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;

    logic             run;
    logic             fifo_full;
    logic             enq;
    logic             pop;
    entry_t           head;
    entry_t           new_entry;
    logic [IDX_W-1:0] ret_idx;
    logic [1:0]       ret_cnt;

    // Handshake, FIFO head decode and saturating counter step
    always_comb begin
        run       = (state_q == ST_RUN);
        fifo_full = (count_q == CNT_W'(DEPTH));
        enq       = upd.upd_valid && run && !fifo_full && !clr_req
                    && (upd.upd_is_br || upd.upd_is_jmp);
        pop       = run && (count_q != '0) && !clr_req;
        head      = fifo_mem[rd_ptr_q];
        ret_idx   = head.pc ^ head.ghr;

        new_entry            = '0;
        new_entry.is_jmp     = upd.upd_is_jmp;
        new_entry.taken      = upd.upd_is_jmp || upd.upd_taken;
        new_entry.pc         = upd.upd_pc;
        new_entry.ghr        = upd.upd_ghr;
`ifdef PHT_STATS_EN
        new_entry.pred_taken = upd.upd_pred_taken;
`endif

        if (head.is_jmp) begin
            ret_cnt = 2'b11;
        end else if (head.taken) begin
            ret_cnt = (pht_rdata == 2'b11) ? 2'b11 : pht_rdata + 2'd1;
        end else begin
            ret_cnt = (pht_rdata == 2'b00) ? 2'b00 : pht_rdata - 2'd1;
        end
    end

    assign upd.upd_ready = run && !fifo_full;
    assign ghr           = ghr_q;
    assign busy          = !run;

    // Table port: sweep writes in CLEAR, RMW on retire, otherwise hold last addresses
    always_comb begin
        pht_we    = 1'b0;
        pht_raddr = raddr_last_q;
        pht_waddr = waddr_last_q;
        pht_wdata = ret_cnt;
        if (!run) begin
            pht_we    = rst_n;
            pht_waddr = sweep_q;
            pht_wdata = INIT_CNT;
        end else if (pop) begin
            pht_we    = 1'b1;
            pht_raddr = ret_idx;
            pht_waddr = ret_idx;
        end
    end

    // Control FSM, sweep index, FIFO pointers and GHR
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_CLEAR;
            sweep_q      <= '0;
            ghr_q        <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            raddr_last_q <= '0;
            waddr_last_q <= '0;
        end else if (clr_req) begin
            state_q  <= ST_CLEAR;
            sweep_q  <= '0;
            ghr_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            case (state_q)
                ST_CLEAR: begin
                    sweep_q      <= sweep_q + IDX_W'(1);
                    waddr_last_q <= sweep_q;
                    if (sweep_q == LAST_IDX) begin
                        state_q <= ST_RUN;
                    end
                end
                default: begin
                    state_q <= ST_RUN;
                end
            endcase

            if (enq) begin
                fifo_mem[wr_ptr_q] <= new_entry;
                wr_ptr_q           <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                ghr_q        <= {ghr_q[IDX_W-2:0], head.taken};
                rd_ptr_q     <= rd_ptr_q + PTR_W'(1);
                raddr_last_q <= ret_idx;
                waddr_last_q <= ret_idx;
            end
            if (enq && !pop) begin
                count_q <= count_q + CNT_W'(1);
            end else if (pop && !enq) begin
                count_q <= count_q - CNT_W'(1);
            end
        end
    end

`ifdef PHT_STATS_EN
    // Retired-branch and misprediction counters, saturating
    always_ff @(posedge clk) begin
        if (!rst_n || clr_req) begin
            stat_upd <= '0;
            stat_mis <= '0;
        end else if (pop && !head.is_jmp) begin
            if (stat_upd != '1) begin
                stat_upd <= stat_upd + 32'd1;
            end
            if ((head.taken != head.pred_taken) && (stat_mis != '1)) begin
                stat_mis <= stat_mis + 32'd1;
            end
        end
    end
`else
    logic unused_pred;
    assign unused_pred = upd.upd_pred_taken;
`endif

endmodule
